// File: rtl/at25010_spi_slave_if.sv
// SPI bus bundle between an SPI master and the AT25010 responder.
// Mode 0: sck idles low, data sampled on the rising edge.
interface at25010_spi_slave_if;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;

    modport slave (
        input  sck,
        input  cs_n,
        input  mosi,
        output miso
    );

    modport master (
        output sck,
        output cs_n,
        output mosi,
        input  miso
    );
endinterface

// File: rtl/at25010_spi_slave.sv
// SPI mode-0 responder emulating an AT25010 128x8 serial EEPROM.
// Supports READ, WRITE, WREN, WRDI, RDSR plus a local preload port.
module at25010_spi_slave #(
    parameter int MEM_DEPTH   = 128,
    parameter int ADDR_W      = 7,
    parameter int PAGE_BYTES  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    at25010_spi_slave_if.slave spi,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              wel,
    output logic              selected
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_RDATA,
        S_WDATA,
        S_STATUS,
        S_IGNORE
    } state_e;

    localparam logic [ADDR_W-1:0] PG_M = ADDR_W'(PAGE_BYTES - 1);

    logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
    logic sck_prev_q;
    logic sck_s, cs_s, mosi_s, rise, fall;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_q, wr_d;
    logic              wel_q, wel_d;
    logic              miso_q, miso_d;

    logic [7:0]        mem_q [MEM_DEPTH];
    logic              mem_we;
    logic [7:0]        rx_byte;
    logic              done;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] pg_next;

    // cs_n synchronizer resets high so the part comes up deselected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q      <= '0;
            cs_q       <= '1;
            mosi_q     <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], spi.sck};
            cs_q       <= {cs_q[SYNC_STAGES-2:0], spi.cs_n};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], spi.mosi};
            sck_prev_q <= sck_s;
        end
    end

    assign sck_s  = sck_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign rise   = sck_s & ~sck_prev_q;
    assign fall   = ~sck_s & sck_prev_q;

    assign rx_byte = {rx_q[6:0], mosi_s};
    assign done    = rise && (bit_cnt_q == 3'd7);
    assign addr_in = rx_byte[ADDR_W-1:0];
    assign pg_next = (ptr_q & ~PG_M) | ((ptr_q + 1'b1) & PG_M);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        wr_d      = wr_q;
        wel_d     = wel_q;
        miso_d    = miso_q;
        mem_we    = 1'b0;

        if (cs_s) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            if (wr_q && (state_q == S_ADDR || state_q == S_WDATA))
                wel_d = 1'b0;
        end else begin
            if (rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (fall && (state_q == S_RDATA || state_q == S_STATUS)) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
            unique case (state_q)
                S_IDLE: begin
                    state_d   = S_CMD;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                end
                S_CMD: if (done) begin
                    case (rx_byte)
                        8'h03: begin
                            state_d = S_ADDR;
                            wr_d    = 1'b0;
                        end
                        8'h02: begin
                            state_d = wel_q ? S_ADDR : S_IGNORE;
                            wr_d    = 1'b1;
                        end
                        8'h06: begin
                            wel_d   = 1'b1;
                            state_d = S_IGNORE;
                        end
                        8'h04: begin
                            wel_d   = 1'b0;
                            state_d = S_IGNORE;
                        end
                        8'h05: begin
                            state_d = S_STATUS;
                            tx_d    = {6'b0, wel_q, 1'b0};
                        end
                        default: state_d = S_IGNORE;
                    endcase
                end
                S_ADDR: if (done) begin
                    if (wr_q) begin
                        ptr_d   = addr_in;
                        state_d = S_WDATA;
                    end else begin
                        tx_d    = mem_q[addr_in];
                        ptr_d   = addr_in + 1'b1;
                        state_d = S_RDATA;
                    end
                end
                S_RDATA: if (done) begin
                    tx_d  = mem_q[ptr_q];
                    ptr_d = ptr_q + 1'b1;
                end
                S_WDATA: if (done) begin
                    mem_we = 1'b1;
                    ptr_d  = pg_next;
                end
                S_STATUS: if (done) begin
                    tx_d = {6'b0, wel_q, 1'b0};
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= '0;
            wr_q      <= 1'b0;
            wel_q     <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wr_q      <= wr_d;
            wel_q     <= wel_d;
            miso_q    <= miso_d;
        end
    end

    // SPI write takes the port; a colliding preload is dropped
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[ptr_q] <= rx_byte;
        else if (ld_we)
            mem_q[ld_addr] <= ld_data;
    end

    assign spi.miso = miso_q;
    assign wel      = wel_q;
    assign selected = ~cs_s;

endmodule

// File: tb/tb_at25010_spi_slave.sv
// Directed bench for the AT25010 SPI responder.
// SPI half period is 8 clk; inputs change 2 ns before a clk edge.
module tb_at25010_spi_slave;

    logic       clk;
    logic       rst_n;
    logic       ld_we;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic       wel;
    logic       selected;
    int         total;
    int         bad;
    logic [7:0] rx;

    at25010_spi_slave_if spi_if ();

    at25010_spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi_if),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .wel      (wel),
        .selected (selected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_we   = 1'b1;
        #10;
        ld_we   = 1'b0;
    endtask

    task automatic cs_lo();
        spi_if.cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_hi();
        #80;
        spi_if.cs_n = 1'b1;
        #160;
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_if.mosi = tx[7-i];
            #80;
            rxb = {rxb[6:0], spi_if.miso};
            spi_if.sck = 1'b1;
            #80;
            spi_if.sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx, output logic [7:0] rxb);
        xfer(tx, 8, rxb);
    endtask

    task automatic read1(input logic [6:0] a, output logic [7:0] d);
        logic [7:0] t;
        cs_lo();
        send(8'h03, t);
        send({1'b0, a}, t);
        send(8'h00, d);
        cs_hi();
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] t;
        cs_lo();
        send(op, t);
        cs_hi();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        ld_we       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        spi_if.sck  = 1'b0;
        spi_if.cs_n = 1'b1;
        spi_if.mosi = 1'b0;
        #23;
        chk("rst_miso", {7'b0, spi_if.miso}, 8'h00);
        chk("rst_wel", {7'b0, wel}, 8'h00);
        chk("rst_sel", {7'b0, selected}, 8'h00);
        rst_n = 1'b1;
        #40;

        // T1 simple read
        preload(7'h2A, 8'h5C);
        cs_lo();
        chk("t1_sel", {7'b0, selected}, 8'h01);
        send(8'h03, rx);
        send(8'h2A, rx);
        send(8'h00, rx);
        chk("t1_data", rx, 8'h5C);
        chk("t1_wel", {7'b0, wel}, 8'h00);
        cs_hi();
        chk("t1_desel", {7'b0, selected}, 8'h00);

        // T2 sequential read wraps 7Fh -> 00h
        preload(7'h7F, 8'h11);
        preload(7'h00, 8'h22);
        cs_lo();
        send(8'h03, rx);
        send(8'h7F, rx);
        send(8'h00, rx);
        chk("t2_b0", rx, 8'h11);
        send(8'h00, rx);
        chk("t2_b1", rx, 8'h22);
        cs_hi();

        // T3 write protect, WREN, RDSR, write
        preload(7'h10, 8'h55);
        cs_lo();
        send(8'h02, rx);
        send(8'h10, rx);
        send(8'hAA, rx);
        cs_hi();
        read1(7'h10, rx);
        chk("t3_prot", rx, 8'h55);
        cmd1(8'h06);
        chk("t3_wren", {7'b0, wel}, 8'h01);
        cs_lo();
        send(8'h05, rx);
        send(8'h00, rx);
        chk("t3_rdsr", rx, 8'h02);
        send(8'h00, rx);
        chk("t3_rdsr2", rx, 8'h02);
        cs_hi();
        cs_lo();
        send(8'h02, rx);
        send(8'h10, rx);
        send(8'hAA, rx);
        cs_hi();
        chk("t3_wel_clr", {7'b0, wel}, 8'h00);
        read1(7'h10, rx);
        chk("t3_wr", rx, 8'hAA);
        cs_lo();
        send(8'h05, rx);
        send(8'h00, rx);
        chk("t3_rdsr0", rx, 8'h00);
        cs_hi();

        // WREN then WRDI
        cmd1(8'h06);
        cmd1(8'h04);
        chk("wrdi", {7'b0, wel}, 8'h00);

        // T4 page wrap
        cmd1(8'h06);
        cs_lo();
        send(8'h02, rx);
        send(8'h0E, rx);
        send(8'hA1, rx);
        send(8'hA2, rx);
        send(8'hA3, rx);
        cs_hi();
        read1(7'h0E, rx);
        chk("t4_0e", rx, 8'hA1);
        read1(7'h0F, rx);
        chk("t4_0f", rx, 8'hA2);
        read1(7'h08, rx);
        chk("t4_08", rx, 8'hA3);

        // T5 partial data byte discarded
        preload(7'h20, 8'h3C);
        cmd1(8'h06);
        cs_lo();
        send(8'h02, rx);
        send(8'h20, rx);
        xfer(8'hF0, 4, rx);
        cs_hi();
        chk("t5_wel", {7'b0, wel}, 8'h00);
        read1(7'h20, rx);
        chk("t5_keep", rx, 8'h3C);

        // T6 reset mid-read
        preload(7'h30, 8'hFF);
        cmd1(8'h06);
        cs_lo();
        send(8'h03, rx);
        send(8'h30, rx);
        xfer(8'h00, 3, rx);
        chk("t6_pre_miso", {7'b0, spi_if.miso}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("t6_miso", {7'b0, spi_if.miso}, 8'h00);
        chk("t6_wel", {7'b0, wel}, 8'h00);
        chk("t6_sel", {7'b0, selected}, 8'h00);
        spi_if.cs_n = 1'b1;
        #39;
        rst_n = 1'b1;
        #40;
        read1(7'h30, rx);
        chk("t6_retry", rx, 8'hFF);
        read1(7'h0E, rx);
        chk("t6_array", rx, 8'hA1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
